// File: rtl/rv_core_pkg.sv
// rv_core_pkg
// Shared definitions for the RV32I core front end: data width, reset PC
// default, the canonical NOP encoding, the fetch FSM state encoding and the
// {pc, instr} fetch-buffer entry.
package rv_core_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Instruction fetches are always word aligned; low address bits are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
// Synchronous FIFO holding fetched {pc, instr} pairs between the fetch
// handshake and decode. The head entry is presented combinationally.
// Flush wins over push and pop in the same cycle.
//
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_push/i_wdata write an entry (ignored while full)
//   i_pop          retire the head entry (ignored while empty)
//   i_flush        discard every entry
//   o_rdata        head entry
//   o_full/o_empty occupancy flags
//   o_count        number of valid entries
module fetch_fifo
  import rv_core_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic               i_flush,
  input  fetch_entry_t       i_wdata,
  output fetch_entry_t       o_rdata,
  output logic               o_full,
  output logic               o_empty,
  output logic [CNT_W-1:0]   o_count
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rptr];

  assign w_do_push = i_push && !o_full  && !i_flush;
  assign w_do_pop  = i_pop  && !o_empty && !i_flush;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers/count.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// RV32I instruction fetch stage. Walks sequential word addresses, fetches
// from instruction memory over a req/ack handshake (one request in flight),
// buffers {pc, instr} pairs in fetch_fifo and presents the head to decode.
// An execute-stage redirect flushes everything and restarts at the target.
//
// Ports:
//   clk_in, rst_in   clock, asynchronous active-high reset
//   imem_req_out     fetch request (dropped combinationally on redirect)
//   imem_addr_out    word-aligned fetch address, stable until acked
//   imem_ack_in      memory completes the request this cycle
//   imem_rdata_in    instruction word, valid with req && ack
//   redirect_in      PC redirect from execute
//   redirect_pc_in   redirect target (low two bits ignored)
//   id_ready_in      decode takes the head entry
//   id_valid_out     head entry valid
//   id_instr_out     head instruction (NOP when not valid)
//   id_pc_out        head PC (zero when not valid)
module instr_fetch_unit
  import rv_core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk_in,
  input  logic            rst_in,
  output logic            imem_req_out,
  output logic [XLEN-1:0] imem_addr_out,
  input  logic            imem_ack_in,
  input  logic [XLEN-1:0] imem_rdata_in,
  input  logic            redirect_in,
  input  logic [XLEN-1:0] redirect_pc_in,
  input  logic            id_ready_in,
  output logic            id_valid_out,
  output logic [XLEN-1:0] id_instr_out,
  output logic [XLEN-1:0] id_pc_out
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_e     r_state;
  logic [XLEN-1:0]  r_fetch_pc;

  logic             w_xfer;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  fetch_entry_t     w_head;
  fetch_entry_t     w_push_data;

  // Request follows the state, but a redirect kills it in the same cycle so
  // memory sees the in-flight fetch as cancelled.
  assign imem_req_out  = (r_state == ST_FETCH) && !redirect_in;
  assign imem_addr_out = r_fetch_pc;
  assign w_xfer        = imem_req_out && imem_ack_in;

  // The head is hidden during a redirect so decode never consumes a
  // wrong-path instruction in the flush cycle.
  assign id_valid_out  = !w_empty && !redirect_in;
  assign w_pop         = id_valid_out && id_ready_in;
  assign id_instr_out  = id_valid_out ? w_head.instr : NOP_INSTR;
  assign id_pc_out     = id_valid_out ? w_head.pc    : '0;

  assign w_push_data.pc    = r_fetch_pc;
  assign w_push_data.instr = imem_rdata_in;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk_in),
    .i_rst   (rst_in),
    .i_push  (w_xfer),
    .i_pop   (w_pop),
    .i_flush (redirect_in),
    .i_wdata (w_push_data),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= ST_BOOT;
      r_fetch_pc <= RESET_PC;
    end else if (redirect_in) begin
      r_state    <= ST_FETCH;
      r_fetch_pc <= word_align(redirect_pc_in);
    end else begin
      // 32-bit wrap from 0xFFFF_FFFC to 0 falls out of the adder width.
      if (w_xfer) r_fetch_pc <= r_fetch_pc + XLEN'(4);
      unique case (r_state)
        ST_BOOT:  r_state <= ST_FETCH;
        // Stop requesting once this push fills the buffer; a concurrent pop
        // keeps the count where it is, so fetching continues.
        ST_FETCH: if (w_xfer && !w_pop && (w_count == CNT_W'(FIFO_DEPTH - 1)))
                    r_state <= ST_HOLD;
        // Resume as soon as decode frees a slot.
        ST_HOLD:  if (w_pop || !w_full) r_state <= ST_FETCH;
        default:  r_state <= ST_BOOT;
      endcase
    end
  end

  // Only bits [31:2] of the redirect target matter.
  logic w_unused_redir_lsb;
  assign w_unused_redir_lsb = ^redirect_pc_in[1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_ack_in = 1'b0;
  logic [31:0] imem_rdata_in;
  logic        redirect_in = 1'b0;
  logic [31:0] redirect_pc_in = '0;
  logic        id_ready_in = 1'b0;
  logic        id_valid_out;
  logic [31:0] id_instr_out;
  logic [31:0] id_pc_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  // Instruction memory contents: a distinct word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0003;
  endfunction

  assign imem_rdata_in = mem_word(imem_addr_out);

  instr_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .imem_req_out   (imem_req_out),
    .imem_addr_out  (imem_addr_out),
    .imem_ack_in    (imem_ack_in),
    .imem_rdata_in  (imem_rdata_in),
    .redirect_in    (redirect_in),
    .redirect_pc_in (redirect_pc_in),
    .id_ready_in    (id_ready_in),
    .id_valid_out   (id_valid_out),
    .id_instr_out   (id_instr_out),
    .id_pc_out      (id_pc_out)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model: a queue of buffered {pc, instr}, the next fetch
  // address, and two flags (first cycle after reset, buffer-full stall).
  // Inputs change just after each rising edge, so at the falling edge they
  // hold exactly what the DUT will sample at the next rising edge: compare
  // first, then advance the model by one clock.
  // ---------------------------------------------------------------------
  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc   = RPC;
  bit          m_boot = 1'b1;
  bit          m_hold = 1'b0;

  initial begin
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        mq.delete();
        m_pc = RPC; m_boot = 1'b1; m_hold = 1'b0;
        chk("m_rst_req",   {31'd0, imem_req_out}, 32'd0);
        chk("m_rst_addr",  imem_addr_out, RPC);
        chk("m_rst_valid", {31'd0, id_valid_out}, 32'd0);
        chk("m_rst_instr", id_instr_out, NOP);
        chk("m_rst_pc",    id_pc_out, 32'd0);
      end else begin
        bit   e_req, e_valid, pop, push;
        e_req   = !m_boot && !m_hold && !redirect_in;
        e_valid = (mq.size() != 0) && !redirect_in;
        chk("m_req", {31'd0, imem_req_out}, {31'd0, e_req});
        if (e_req) chk("m_addr", imem_addr_out, m_pc);
        chk("m_valid", {31'd0, id_valid_out}, {31'd0, e_valid});
        chk("m_pc",    id_pc_out,    e_valid ? mq[0].pc    : 32'd0);
        chk("m_instr", id_instr_out, e_valid ? mq[0].instr : NOP);
        if (redirect_in) begin
          mq.delete();
          m_pc   = {redirect_pc_in[31:2], 2'b00};
          m_hold = 1'b0;
        end else begin
          pop  = e_valid && id_ready_in;
          push = e_req && imem_ack_in;
          if (pop) void'(mq.pop_front());
          if (push) begin
            mq.push_back({m_pc, mem_word(m_pc)});
            m_pc = m_pc + 32'd4;
          end
          if (m_hold && pop) m_hold = 1'b0;
          else if (push && mq.size() == DEPTH) m_hold = 1'b1;
        end
        m_boot = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Directed stimulus with literal expectations (checked 2 time units
  // after each rising edge, once the new inputs have settled).
  // ---------------------------------------------------------------------
  task automatic step();
    @(posedge clk_in); #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1; redirect_in = 1'b0; imem_ack_in = 1'b0; id_ready_in = 1'b0;
    step(); step();
    rst_in = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    redirect_in = 1'b1; redirect_pc_in = tgt;
  endtask

  initial begin
    // 1: streaming, ack every cycle, decode always ready
    do_reset();
    imem_ack_in = 1'b1; id_ready_in = 1'b1; #1;
    chk("c0_req",   {31'd0, imem_req_out}, 32'd0);
    chk("c0_valid", {31'd0, id_valid_out}, 32'd0);
    chk("c0_instr", id_instr_out, NOP);
    step(); #1;
    chk("c1_req",  {31'd0, imem_req_out}, 32'd1);
    chk("c1_addr", imem_addr_out, 32'h0);
    step(); #1;
    chk("c2_addr",  imem_addr_out, 32'h4);
    chk("c2_valid", {31'd0, id_valid_out}, 32'd1);
    chk("c2_pc",    id_pc_out, 32'h0);
    chk("c2_instr", id_instr_out, mem_word(32'h0));
    step(); #1;
    chk("c3_addr", imem_addr_out, 32'h8);
    chk("c3_pc",   id_pc_out, 32'h4);

    // 2: decode stalled, buffer fills after two pushes, then resumes
    do_reset();
    imem_ack_in = 1'b1; id_ready_in = 1'b0;
    step(); step(); #1;
    chk("st_c2_addr", imem_addr_out, 32'h4);
    step(); #1;
    chk("st_c3_req", {31'd0, imem_req_out}, 32'd0);
    chk("st_c3_pc",  id_pc_out, 32'h0);
    step(); #1;
    chk("st_c4_req", {31'd0, imem_req_out}, 32'd0);
    id_ready_in = 1'b1;
    step(); #1;
    chk("st_c5_req",  {31'd0, imem_req_out}, 32'd1);
    chk("st_c5_addr", imem_addr_out, 32'h8);
    chk("st_c5_pc",   id_pc_out, 32'h4);

    // 3: slow memory at 0x10, ack on the 4th request cycle
    imem_ack_in = 1'b0; redirect_to(32'h10); #1;
    chk("sl_redir_valid", {31'd0, id_valid_out}, 32'd0);
    chk("sl_redir_req",   {31'd0, imem_req_out}, 32'd0);
    step(); redirect_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) imem_ack_in = 1'b1;
      #1;
      chk("sl_wait_req",   {31'd0, imem_req_out}, 32'd1);
      chk("sl_wait_addr",  imem_addr_out, 32'h10);
      chk("sl_wait_valid", {31'd0, id_valid_out}, 32'd0);
      step();
    end
    imem_ack_in = 1'b0; #1;
    chk("sl_pc",    id_pc_out, 32'h10);
    chk("sl_instr", id_instr_out, mem_word(32'h10));
    chk("sl_addr",  imem_addr_out, 32'h14);
    step(); #1;
    chk("sl_nodup", {31'd0, id_valid_out}, 32'd0);

    // 4: redirect while full with a concurrent ack; then back-to-back
    do_reset();
    imem_ack_in = 1'b1; id_ready_in = 1'b0;
    step(); step(); step();
    redirect_to(32'h0000_0103); #1;
    chk("rd_valid", {31'd0, id_valid_out}, 32'd0);
    chk("rd_req",   {31'd0, imem_req_out}, 32'd0);
    step(); redirect_in = 1'b0; id_ready_in = 1'b1; #1;
    chk("rd_addr",  imem_addr_out, 32'h100);
    chk("rd_flush", {31'd0, id_valid_out}, 32'd0);
    step(); #1;
    chk("rd_first_pc", id_pc_out, 32'h100);
    redirect_to(32'h200);
    step(); redirect_to(32'h300); #1;
    chk("b2b_req", {31'd0, imem_req_out}, 32'd0);
    step(); redirect_in = 1'b0; #1;
    chk("b2b_addr", imem_addr_out, 32'h300);
    step(); #1;
    chk("b2b_pc", id_pc_out, 32'h300);

    // 5: address wrap
    redirect_to(32'hFFFF_FFFC);
    step(); redirect_in = 1'b0; #1;
    chk("wr_addr0", imem_addr_out, 32'hFFFF_FFFC);
    step(); #1;
    chk("wr_addr1", imem_addr_out, 32'h0);
    chk("wr_pc",    id_pc_out, 32'hFFFF_FFFC);
    chk("wr_instr", id_instr_out, mem_word(32'hFFFF_FFFC));

    // 6: reset mid-transfer at 0x20 with one entry buffered
    id_ready_in = 1'b0; redirect_to(32'h1C);
    step(); redirect_in = 1'b0;
    step(); imem_ack_in = 1'b0; #1;
    chk("mr_addr",  imem_addr_out, 32'h20);
    chk("mr_valid", {31'd0, id_valid_out}, 32'd1);
    rst_in = 1'b1; #1;
    chk("mr_rst_req",   {31'd0, imem_req_out}, 32'd0);
    chk("mr_rst_addr",  imem_addr_out, RPC);
    chk("mr_rst_valid", {31'd0, id_valid_out}, 32'd0);
    chk("mr_rst_instr", id_instr_out, NOP);
    chk("mr_rst_pc",    id_pc_out, 32'd0);
    step(); step();
    rst_in = 1'b0; imem_ack_in = 1'b1; id_ready_in = 1'b1; #1;
    chk("mr_c0_req", {31'd0, imem_req_out}, 32'd0);
    step(); #1;
    chk("mr_c1_addr", imem_addr_out, RPC);
    chk("mr_c1_req",  {31'd0, imem_req_out}, 32'd1);
    step(); #1;
    chk("mr_c2_pc", id_pc_out, RPC);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
